axis_mash11_mod: RTL and testbench

- Sink for the unsigned 16-bit AXI-Stream sample stream produced by the NCO.
- Holds each accepted sample for OSR clock cycles (zero-order-hold upsampling).
- Runs a MASH 1-1 (two cascaded first-order error-feedback accumulators) every cycle and emits a 2-bit code to the DAC driver.
- Paces the NCO through s_axis_data_tready: one sample per OSR cycles.

---
 rtl/mash_pkg.sv | 15 +
 rtl/mash_stage.sv | 30 +++
 rtl/axis_mash11_mod.sv | 123 ++++++++++++
 tb/tb_axis_mash11_mod.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mash_pkg.sv
// Shared types and constants for the MASH 1-1 sigma-delta modulator.
package mash_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  typedef logic [1:0] code_t;

  localparam code_t CODE_ZERO = 2'd1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mash_stage.sv
// First-order error-feedback accumulator: the carry is the quantised output and the residue is the error fed onward.
module mash_stage #(
  parameter int unsigned WIDTH = mash_pkg::DATA_WIDTH
) (
  input  logic             aclk,
  input  logic             arst,
  input  logic             step,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             carry,
  output logic [WIDTH-1:0] residue
);
  import mash_pkg::*;

  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;

  assign sum     = {1'b0, acc} + {1'b0, din};
  assign carry   = sum[WIDTH];
  assign residue = sum[WIDTH-1:0];

  always_ff @(posedge aclk) begin
    if (arst || clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= residue;
    end
  end

endmodule

// File: rtl/axis_mash11_mod.sv
// AXI-Stream sink that zero-order-holds each sample for OSR cycles and drives a MASH 1-1 modulator.
// Emits a 2-bit code (y+1) every RUN cycle and paces the source with one tready slot per OSR cycles.
module axis_mash11_mod #(
  parameter int unsigned DATA_WIDTH = mash_pkg::DATA_WIDTH,
  parameter int unsigned OSR        = 64
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,
  output mash_pkg::code_t       m_axis_mod_tdata,
  output logic                  m_axis_mod_tvalid,
  output logic                  underflow
);
  import mash_pkg::*;

  localparam int unsigned CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      os_cnt;
  logic [DATA_WIDTH-1:0] x;
  logic                  c2_d;
  logic                  run_step;
  logic                  slot;
  logic                  c1;
  logic                  c2;
  logic [DATA_WIDTH-1:0] r1;
  logic [DATA_WIDTH-1:0] r2;

  // Next state and pacing; tready never looks at tvalid.
  always_comb begin
    state_nxt          = state;
    s_axis_data_tready = 1'b0;
    run_step           = 1'b0;
    slot               = 1'b0;
    case (state)
      IDLE: begin
        s_axis_data_tready = en;
        if (en && s_axis_data_tvalid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        slot               = (os_cnt == CNT_LAST);
        s_axis_data_tready = en && slot;
        run_step           = en;
        if (!en) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  mash_stage #(.WIDTH(DATA_WIDTH)) u_stage1 (
    .aclk    (aclk),
    .arst    (arst),
    .step    (run_step),
    .clear   (!en),
    .din     (x),
    .carry   (c1),
    .residue (r1)
  );

  mash_stage #(.WIDTH(DATA_WIDTH)) u_stage2 (
    .aclk    (aclk),
    .arst    (arst),
    .step    (run_step),
    .clear   (!en),
    .din     (r1),
    .carry   (c2),
    .residue (r2)
  );

  // Sample hold, hold counter, and code output; y+1 = c1 + c2 + !c2_d stays within 0..3.
  always_ff @(posedge aclk) begin
    if (arst) begin
      os_cnt            <= '0;
      x                 <= '0;
      c2_d              <= 1'b0;
      m_axis_mod_tdata  <= CODE_ZERO;
      m_axis_mod_tvalid <= 1'b0;
      underflow         <= 1'b0;
    end else if (!en) begin
      os_cnt            <= '0;
      c2_d              <= 1'b0;
      m_axis_mod_tdata  <= CODE_ZERO;
      m_axis_mod_tvalid <= 1'b0;
    end else if (state == IDLE) begin
      m_axis_mod_tdata  <= CODE_ZERO;
      m_axis_mod_tvalid <= 1'b0;
      if (s_axis_data_tvalid) begin
        x      <= s_axis_data_tdata;
        os_cnt <= '0;
      end
    end else begin
      os_cnt            <= slot ? '0 : os_cnt + CNT_W'(1);
      c2_d              <= c2;
      m_axis_mod_tdata  <= 2'(c1) + 2'(c2) + 2'(!c2_d);
      m_axis_mod_tvalid <= 1'b1;
      if (slot) begin
        if (s_axis_data_tvalid) begin
          x <= s_axis_data_tdata;
        end else begin
          underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_mash11_mod.sv
// Directed bench for axis_mash11_mod with OSR=4, OSR=2 and OSR=8 instances on shared stimulus.
module tb_axis_mash11_mod;
  import mash_pkg::*;

  logic        aclk = 1'b0;
  logic        arst;
  logic        en;
  logic        tvalid;
  logic [15:0] tdata;
  logic        rdy4, rdy2, rdy8;
  code_t       code4, code2, code8;
  logic        v4, v2, v8;
  logic        uf4, uf2, uf8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  axis_mash11_mod #(.DATA_WIDTH(16), .OSR(4)) dut4 (
    .aclk(aclk), .arst(arst), .en(en),
    .s_axis_data_tdata(tdata), .s_axis_data_tvalid(tvalid), .s_axis_data_tready(rdy4),
    .m_axis_mod_tdata(code4), .m_axis_mod_tvalid(v4), .underflow(uf4));

  axis_mash11_mod #(.DATA_WIDTH(16), .OSR(2)) dut2 (
    .aclk(aclk), .arst(arst), .en(en),
    .s_axis_data_tdata(tdata), .s_axis_data_tvalid(tvalid), .s_axis_data_tready(rdy2),
    .m_axis_mod_tdata(code2), .m_axis_mod_tvalid(v2), .underflow(uf2));

  axis_mash11_mod #(.DATA_WIDTH(16), .OSR(8)) dut8 (
    .aclk(aclk), .arst(arst), .en(en),
    .s_axis_data_tdata(tdata), .s_axis_data_tvalid(tvalid), .s_axis_data_tready(rdy8),
    .m_axis_mod_tdata(code8), .m_axis_mod_tvalid(v8), .underflow(uf8));

  task automatic tick();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic do_reset();
    arst = 1'b1; en = 1'b0; tvalid = 1'b0; tdata = 16'd0;
    tick();
    arst = 1'b0;
    #1;
  endtask

  // Advance until the chosen instance offers a slot; an expired bound counts as a failure.
  task automatic wait_slot(input int which, input int limit);
    logic r;
    r = (which == 8) ? rdy8 : rdy4;
    for (int i = 0; i < limit && !r; i++) begin
      tick();
      r = (which == 8) ? rdy8 : rdy4;
    end
    n_checks++;
    if (r !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_slot%0d: tready never rose within %0d cycles", which, limit);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (v4 !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", v4); end
    n_checks++; if (code4 !== 2'd1) begin n_fail++; $display("FAIL rst_code: got %0d want 1", code4); end
    n_checks++; if (uf4 !== 1'b0) begin n_fail++; $display("FAIL rst_underflow: got %b want 0", uf4); end
    n_checks++; if (rdy4 !== 1'b0) begin n_fail++; $display("FAIL rst_tready_en0: got %b want 0", rdy4); end
    en = 1'b1; tvalid = 1'b1; tdata = 16'd0;
    #1;
    n_checks++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL idle_tready: got %b want 1", rdy4); end
    tick();
    n_checks++; if (v4 !== 1'b0) begin n_fail++; $display("FAIL lat1_tvalid: got %b want 0", v4); end
    tick();
    n_checks++; if (v4 !== 1'b1) begin n_fail++; $display("FAIL lat2_tvalid: got %b want 1", v4); end
    for (int i = 0; i < 1000; i++) begin
      n_checks++;
      if (code4 !== 2'd1 || v4 !== 1'b1) begin
        n_fail++; $display("FAIL zero_code[%0d]: got code %0d valid %b want code 1 valid 1", i, code4, v4);
      end
      tick();
    end
    n_checks++; if (uf4 !== 1'b0) begin n_fail++; $display("FAIL zero_underflow: got %b want 0", uf4); end
  endtask

  task automatic test_half();
    int    sum;
    code_t exp_first [4];
    exp_first = '{2'd1, 2'd2, 2'd2, 2'd1};
    sum = 0;
    do_reset();
    en = 1'b1; tvalid = 1'b1; tdata = 16'd32768;
    tick();
    for (int k = 1; k <= 257; k++) begin
      n_checks++;
      if (rdy4 !== (((k - 1) % 4) == 3)) begin
        n_fail++; $display("FAIL half_tready4[%0d]: got %b want %b", k, rdy4, (((k - 1) % 4) == 3));
      end
      n_checks++;
      if (rdy2 !== (((k - 1) % 2) == 1)) begin
        n_fail++; $display("FAIL half_tready2[%0d]: got %b want %b", k, rdy2, (((k - 1) % 2) == 1));
      end
      if (k >= 2) begin
        if (k - 2 < 4) begin
          n_checks++;
          if (code4 !== exp_first[k-2]) begin
            n_fail++; $display("FAIL half_code[%0d]: got %0d want %0d", k - 2, code4, exp_first[k-2]);
          end
        end
        sum += int'(code4) - 1;
      end
      tick();
    end
    n_checks++;
    if (sum < 126 || sum > 130) begin n_fail++; $display("FAIL half_sum: got %0d want 126..130", sum); end
  endtask

  task automatic test_quarter();
    int sum;
    sum = 0;
    do_reset();
    en = 1'b1; tvalid = 1'b1; tdata = 16'd16384;
    tick();
    tick();
    for (int i = 0; i < 1024; i++) begin
      n_checks++;
      if (v4 !== 1'b1 || $isunknown(code4)) begin
        n_fail++; $display("FAIL quarter_valid[%0d]: got valid %b code %0d want valid 1", i, v4, code4);
      end
      sum += int'(code4) - 1;
      tick();
    end
    n_checks++;
    if (sum < 254 || sum > 258) begin n_fail++; $display("FAIL quarter_sum: got %0d want 254..258", sum); end
  endtask

  task automatic test_step();
    int sum;
    sum = 0;
    do_reset();
    en = 1'b1; tvalid = 1'b1; tdata = 16'd8192;
    tick();
    for (int i = 0; i < 40; i++) tick();
    wait_slot(4, 8);
    tdata = 16'd57344;
    tick();
    tick();
    for (int i = 0; i < 512; i++) begin
      sum += int'(code4) - 1;
      tick();
    end
    n_checks++;
    if (sum < 443 || sum > 453) begin n_fail++; $display("FAIL step_sum: got %0d want 443..453", sum); end
  endtask

  task automatic test_underflow();
    int sum;
    sum = 0;
    do_reset();
    en = 1'b1; tvalid = 1'b1; tdata = 16'd16384;
    tick();
    wait_slot(8, 16);
    n_checks++; if (uf8 !== 1'b0) begin n_fail++; $display("FAIL uf_before: got %b want 0", uf8); end
    tvalid = 1'b0;
    tdata  = 16'd65535;
    tick();
    n_checks++; if (uf8 !== 1'b1) begin n_fail++; $display("FAIL uf_after: got %b want 1", uf8); end
    tvalid = 1'b1;
    tdata  = 16'd16384;
    for (int i = 0; i < 512; i++) begin
      sum += int'(code8) - 1;
      tick();
    end
    n_checks++;
    if (sum < 126 || sum > 130) begin n_fail++; $display("FAIL uf_hold_sum: got %0d want 126..130", sum); end
    en = 1'b0;
    tick();
    n_checks++; if (uf8 !== 1'b1) begin n_fail++; $display("FAIL uf_en_off: got %b want 1", uf8); end
    n_checks++; if (v8 !== 1'b0) begin n_fail++; $display("FAIL en_off_valid: got %b want 0", v8); end
    n_checks++; if (code8 !== 2'd1) begin n_fail++; $display("FAIL en_off_code: got %0d want 1", code8); end
    n_checks++; if (rdy8 !== 1'b0) begin n_fail++; $display("FAIL en_off_tready: got %b want 0", rdy8); end
    en = 1'b1;
    #1;
    n_checks++; if (rdy8 !== 1'b1) begin n_fail++; $display("FAIL en_on_tready: got %b want 1", rdy8); end
    tick();
    tick();
    n_checks++; if (uf8 !== 1'b1) begin n_fail++; $display("FAIL uf_en_on: got %b want 1", uf8); end
    do_reset();
    n_checks++; if (uf8 !== 1'b0) begin n_fail++; $display("FAIL uf_arst: got %b want 0", uf8); end
  endtask

  task automatic test_en_slot();
    do_reset();
    en = 1'b1; tvalid = 1'b1; tdata = 16'd16384;
    tick();
    wait_slot(4, 8);
    en = 1'b0;
    tdata = 16'd65535;
    #1;
    n_checks++; if (rdy4 !== 1'b0) begin n_fail++; $display("FAIL en_slot_tready: got %b want 0", rdy4); end
    tick();
    n_checks++; if (v4 !== 1'b0) begin n_fail++; $display("FAIL en_slot_valid: got %b want 0", v4); end
    n_checks++; if (code4 !== 2'd1) begin n_fail++; $display("FAIL en_slot_code: got %0d want 1", code4); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    en = 1'b1; tvalid = 1'b1; tdata = 16'd32768;
    tick();
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (v4 !== 1'b1) begin n_fail++; $display("FAIL mid_run_valid: got %b want 1", v4); end
    arst = 1'b1;
    tick();
    n_checks++; if (v4 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", v4); end
    n_checks++; if (code4 !== 2'd1) begin n_fail++; $display("FAIL mid_rst_code: got %0d want 1", code4); end
    n_checks++; if (uf4 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_underflow: got %b want 0", uf4); end
    n_checks++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL mid_rst_tready: got %b want 1", rdy4); end
    arst  = 1'b0;
    tdata = 16'd0;
    tick();
    n_checks++; if (v4 !== 1'b0) begin n_fail++; $display("FAIL restart_lat1: got %b want 0", v4); end
    tick();
    n_checks++; if (v4 !== 1'b1) begin n_fail++; $display("FAIL restart_lat2: got %b want 1", v4); end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (code4 !== 2'd1) begin n_fail++; $display("FAIL restart_code[%0d]: got %0d want 1", i, code4); end
      tick();
    end
  endtask

  initial begin
    arst = 1'b1; en = 1'b0; tvalid = 1'b0; tdata = 16'd0;
    @(negedge aclk);
    test_reset();
    test_half();
    test_quarter();
    test_step();
    test_underflow();
    test_en_slot();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
